// File: rtl/gear_shift_ctrl_if.sv
// Handshake bundle between the gear-select stage and the shift controller.
// The controller takes the slave view; the stimulus side takes the master view.
interface gear_shift_ctrl_if;
    logic       enable;
    logic [1:0] target_gear;
    logic [1:0] gear;
    logic       clutch;
    logic       busy;
    logic       shift_done;

    modport master (
        output enable,
        output target_gear,
        input  gear,
        input  clutch,
        input  busy,
        input  shift_done
    );

    modport slave (
        input  enable,
        input  target_gear,
        output gear,
        output clutch,
        output busy,
        output shift_done
    );
endinterface

// File: rtl/gear_shift_ctrl.sv
// Sequential gearbox shift controller: qualifies a stable gear request, then
// opens the clutch, steps the gear by one, closes the clutch and dwells.
module gear_shift_ctrl #(
    parameter int unsigned STABLE_CYC = 4,
    parameter int unsigned CLUTCH_CYC = 2,
    parameter int unsigned DWELL_CYC  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    gear_shift_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_QUAL  = 3'd1,
        ST_OPEN  = 3'd2,
        ST_MOVE  = 3'd3,
        ST_CLOSE = 3'd4,
        ST_DWELL = 3'd5
    } state_t;

    // Counter values on which each timed state ends
    localparam logic [7:0] L_STABLE_LAST = 8'(STABLE_CYC - 32'd1);
    localparam logic [7:0] L_CLUTCH_LAST = 8'(CLUTCH_CYC - 32'd1);
    localparam logic [7:0] L_DWELL_LAST  = 8'(DWELL_CYC - 32'd1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic [1:0] r_tgt_l;
    logic [1:0] w_tgt_nxt;
    logic [1:0] r_gear;
    logic [1:0] w_gear_nxt;
    logic       r_clutch;
    logic       w_clutch_nxt;
    logic       r_busy;
    logic       w_busy_nxt;
    logic       r_shift_done;
    logic       w_shift_done_nxt;
    logic       w_req_valid;

    // One step toward the latched target; saturates at both ends
    function automatic logic [1:0] f_step_gear(input logic [1:0] cur, input logic [1:0] tgt);
        logic [1:0] res;
        if ((tgt > cur) && (cur != 2'd3)) begin
            res = cur + 2'd1;
        end else if ((tgt < cur) && (cur != 2'd0)) begin
            res = cur - 2'd1;
        end else begin
            res = cur;
        end
        return res;
    endfunction

    assign w_req_valid = bus.enable && (bus.target_gear != r_gear);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, shared counter and target latch
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tgt_nxt   = r_tgt_l;
        case (r_state)
            ST_IDLE: begin
                if (w_req_valid) begin
                    w_tgt_nxt = bus.target_gear;
                    if (L_STABLE_LAST == 8'd0) begin
                        w_state_nxt = ST_OPEN;
                        w_cnt_nxt   = 8'd0;
                    end else begin
                        w_state_nxt = ST_QUAL;
                        w_cnt_nxt   = 8'd1;
                    end
                end else begin
                    w_cnt_nxt = 8'd0;
                end
            end
            ST_QUAL: begin
                if (w_req_valid && (bus.target_gear == r_tgt_l)) begin
                    if (r_cnt == L_STABLE_LAST) begin
                        w_state_nxt = ST_OPEN;
                        w_cnt_nxt   = 8'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 8'd0;
                end
            end
            ST_OPEN: begin
                if (r_cnt == L_CLUTCH_LAST) begin
                    w_state_nxt = ST_MOVE;
                    w_cnt_nxt   = 8'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            ST_MOVE: begin
                w_state_nxt = ST_CLOSE;
                w_cnt_nxt   = 8'd0;
            end
            ST_CLOSE: begin
                if (r_cnt == L_CLUTCH_LAST) begin
                    w_state_nxt = ST_DWELL;
                    w_cnt_nxt   = 8'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            ST_DWELL: begin
                if (r_cnt == L_DWELL_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 8'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    // Next output values, decoded from the upcoming state so outputs stay registered
    always_comb begin
        w_gear_nxt       = r_gear;
        w_clutch_nxt     = 1'b0;
        w_busy_nxt       = 1'b0;
        w_shift_done_nxt = 1'b0;
        if (r_state == ST_MOVE) begin
            w_gear_nxt = f_step_gear(r_gear, r_tgt_l);
        end else begin
            w_gear_nxt = r_gear;
        end
        case (w_state_nxt)
            ST_OPEN, ST_MOVE, ST_CLOSE: begin
                w_clutch_nxt = 1'b1;
                w_busy_nxt   = 1'b1;
            end
            ST_DWELL: begin
                w_busy_nxt       = 1'b1;
                w_shift_done_nxt = (r_state == ST_CLOSE);
            end
            default: begin
                w_clutch_nxt = 1'b0;
                w_busy_nxt   = 1'b0;
            end
        endcase
    end

    // Counter and latched target registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= 8'd0;
            r_tgt_l <= 2'd0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_tgt_l <= w_tgt_nxt;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gear       <= 2'd0;
            r_clutch     <= 1'b0;
            r_busy       <= 1'b0;
            r_shift_done <= 1'b0;
        end else begin
            r_gear       <= w_gear_nxt;
            r_clutch     <= w_clutch_nxt;
            r_busy       <= w_busy_nxt;
            r_shift_done <= w_shift_done_nxt;
        end
    end

    assign bus.gear       = r_gear;
    assign bus.clutch     = r_clutch;
    assign bus.busy       = r_busy;
    assign bus.shift_done = r_shift_done;

endmodule

// File: tb/tb_gear_shift_ctrl.sv
// Bench for gear_shift_ctrl: directed scenarios plus randomized traffic,
// checked each cycle against a timeline model of the shift sequence.
module tb_gear_shift_ctrl;

    localparam int S = 4;
    localparam int C = 2;
    localparam int D = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    gear_shift_ctrl_if bus ();

    gear_shift_ctrl #(
        .STABLE_CYC (S),
        .CLUTCH_CYC (C),
        .DWELL_CYC  (D)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: edge index, edge on which the last shift was qualified, run length
    int e      = 0;
    int m_k    = -1000;
    int m_run  = 0;
    int m_tgt  = 0;
    int m_gear = 0;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, act, exp, e);
        end
    endtask

    function automatic bit m_in_seq(input int x);
        return (x > m_k) && (x <= m_k + 2*C + 1 + D);
    endfunction

    task automatic model_edge(input bit en, input int tg);
        e++;
        if (m_in_seq(e)) begin
            if (e == m_k + C + 1) m_gear = (m_tgt > m_gear) ? m_gear + 1 : m_gear - 1;
        end else if (m_run == 0) begin
            if (en && tg != m_gear) begin
                m_tgt = tg;
                m_run = 1;
            end
        end else if (en && tg == m_tgt) begin
            m_run++;
        end else begin
            m_run = 0;
        end
        if (m_run == S) begin
            m_k   = e;
            m_run = 0;
        end
    endtask

    task automatic check_outputs();
        check_eq("gear",       int'(bus.gear),       m_gear);
        check_eq("clutch",     int'(bus.clutch),     int'(e >= m_k && e < m_k + 2*C + 1));
        check_eq("busy",       int'(bus.busy),       int'(e >= m_k && e < m_k + 2*C + 1 + D));
        check_eq("shift_done", int'(bus.shift_done), int'(e == m_k + 2*C + 1));
    endtask

    // Apply inputs at the falling edge, clock once, check at the next falling edge
    task automatic cyc(input bit en, input int tg);
        bus.enable      = en;
        bus.target_gear = 2'(tg);
        @(posedge clk);
        model_edge(en, tg);
        @(negedge clk);
        check_outputs();
    endtask

    // Reset pulse placed between clock edges; outputs must clear without a clock
    task automatic areset(input string tag);
        #1 rst_n = 1'b0;
        #1;
        check_eq({tag, "_rst_gear"},   int'(bus.gear),       0);
        check_eq({tag, "_rst_clutch"}, int'(bus.clutch),     0);
        check_eq({tag, "_rst_busy"},   int'(bus.busy),       0);
        check_eq({tag, "_rst_done"},   int'(bus.shift_done), 0);
        #1 rst_n = 1'b1;
        m_k    = -1000;
        m_run  = 0;
        m_gear = 0;
    endtask

    initial begin
        int pulses;
        bit found;
        bit en;
        int tg;

        bus.enable      = 1'b0;
        bus.target_gear = 2'd0;
        repeat (3) @(negedge clk);
        check_eq("init_gear",   int'(bus.gear),   0);
        check_eq("init_clutch", int'(bus.clutch), 0);
        check_eq("init_busy",   int'(bus.busy),   0);
        rst_n = 1'b1;

        // Single upshift with the documented edge timing
        for (int i = 1; i <= 20; i++) begin
            cyc(1'b1, 1);
            if (i == 3)  check_eq("t_clutch_e3", int'(bus.clutch), 0);
            if (i == 4)  check_eq("t_clutch_e4", int'(bus.clutch), 1);
            if (i == 6)  check_eq("t_gear_e6",   int'(bus.gear), 0);
            if (i == 7)  check_eq("t_gear_e7",   int'(bus.gear), 1);
            if (i == 9)  check_eq("t_done_e9",   int'(bus.shift_done), 1);
            if (i == 9)  check_eq("t_clutch_e9", int'(bus.clutch), 0);
            if (i == 10) check_eq("t_done_e10",  int'(bus.shift_done), 0);
            if (i == 16) check_eq("t_busy_e16",  int'(bus.busy), 1);
            if (i == 17) check_eq("t_busy_e17",  int'(bus.busy), 0);
        end

        // Short-lived request is not qualified
        areset("abort");
        for (int i = 1; i <= 3; i++) cyc(1'b1, 2);
        for (int i = 1; i <= 10; i++) cyc(1'b1, 0);
        check_eq("abort_gear", int'(bus.gear), 0);
        check_eq("abort_busy", int'(bus.busy), 0);

        // Multi-step request served one gear per sequence
        areset("multi");
        pulses = 0;
        for (int i = 1; i <= 50; i++) begin
            cyc(1'b1, 3);
            if (bus.shift_done) pulses++;
            if (i == 7)  check_eq("multi_gear_e7",  int'(bus.gear), 1);
            if (i == 24) check_eq("multi_gear_e24", int'(bus.gear), 2);
            if (i == 41) check_eq("multi_gear_e41", int'(bus.gear), 3);
        end
        check_eq("multi_pulses", pulses, 3);

        // Inputs changed during CLOSE/DWELL are ignored until IDLE
        areset("late");
        for (int i = 1; i <= 30; i++) begin
            if (i <= 7)       cyc(1'b1, 1);
            else if (i <= 17) cyc(1'b0, 0);
            else              cyc(1'b1, 0);
            if (i == 17) check_eq("late_gear_e17", int'(bus.gear), 1);
            if (i == 20) check_eq("late_clutch_e20", int'(bus.clutch), 0);
            if (i == 24) check_eq("late_gear_e24", int'(bus.gear), 0);
        end

        // Asynchronous reset while in MOVE at gear 2
        areset("move");
        for (int i = 1; i <= 40; i++) cyc(1'b1, 2);
        found = 1'b0;
        for (int i = 1; i <= 30 && !found; i++) begin
            cyc(1'b1, 3);
            if (e == m_k + C) found = 1'b1;
        end
        check_eq("move_reached", int'(found), 1);
        check_eq("move_gear_pre", int'(bus.gear), 2);
        areset("move");
        for (int i = 1; i <= 6; i++) begin
            cyc(1'b1, 3);
            if (i == 3) check_eq("move_requal_e3", int'(bus.clutch), 0);
            if (i == 4) check_eq("move_requal_e4", int'(bus.clutch), 1);
        end

        // Enable low holds IDLE; enable drop inside QUAL aborts
        areset("en");
        for (int i = 1; i <= 50; i++) cyc(1'b0, 3);
        check_eq("en_low_busy", int'(bus.busy), 0);
        cyc(1'b1, 3);
        cyc(1'b1, 3);
        cyc(1'b0, 3);
        for (int i = 1; i <= 5; i++) cyc(1'b0, 3);
        check_eq("en_drop_clutch", int'(bus.clutch), 0);
        check_eq("en_drop_gear",   int'(bus.gear), 0);

        // Randomized traffic with occasional asynchronous resets
        areset("rand");
        en = 1'b1;
        tg = 0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0) tg = int'($urandom_range(0, 3));
            en = ($urandom_range(0, 15) != 0);
            cyc(en, tg);
            if ($urandom_range(0, 299) == 0) areset("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
